// File: rtl/inv_shift_rows.sv
// AES InvShiftRows stage: captures a state word, rotates one row per clock in place, then presents it.
// Optional macro INV_SHIFT_ROWS_FWD_EN adds the fwd port selecting the encrypt-side ShiftRows direction.
module inv_shift_rows #(
  parameter  int DIMENSION = 4,
  localparam int W         = 8 * DIMENSION * DIMENSION
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef INV_SHIFT_ROWS_FWD_EN
  ,
  input  logic         fwd
`endif
);

  localparam int CNT_W = $clog2(DIMENSION);

  // state   | meaning
  // S_IDLE  | waiting for a word, in_ready=1
  // S_SHIFT | rotating row r_row_cnt of r_work each cycle
  // S_DONE  | result held on out_data, out_valid=1
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_row_cnt;
  logic [CNT_W-1:0] w_row_cnt_nxt;
  logic [W-1:0]     r_work;
  logic [W-1:0]     w_work_nxt;
  logic [W-1:0]     w_rotated;
  logic             w_capture;
  logic             w_dir_fwd;

`ifdef INV_SHIFT_ROWS_FWD_EN
  logic r_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd <= 1'b0;
    end else if (w_capture) begin
      r_fwd <= fwd;
    end
  end

  assign w_dir_fwd = r_fwd;
`else
  assign w_dir_fwd = 1'b0;
`endif

  // Only the row selected by r_row_cnt moves; every other byte keeps its value.
  always_comb begin
    w_rotated = r_work;
    for (int r = 0; r < DIMENSION; r++) begin
      if (r == int'(r_row_cnt)) begin
        for (int c = 0; c < DIMENSION; c++) begin
          w_rotated[W-1-8*(c*DIMENSION+r) -: 8] = w_dir_fwd
            ? r_work[W-1-8*(((c + r) % DIMENSION)*DIMENSION + r) -: 8]
            : r_work[W-1-8*(((c + DIMENSION - r) % DIMENSION)*DIMENSION + r) -: 8];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_work_nxt    = r_work;
    w_capture     = 1'b0;
    in_ready      = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_capture = 1'b1;
        end
      end
      S_SHIFT: begin
        w_work_nxt = w_rotated;
        if (r_row_cnt == CNT_W'(DIMENSION - 1)) begin
          w_state_nxt   = S_DONE;
          w_row_cnt_nxt = '0;
        end else begin
          w_row_cnt_nxt = r_row_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_row_cnt_nxt = '0;
      end
    endcase
    if (w_capture) begin
      w_work_nxt    = in_data;
      w_row_cnt_nxt = '0;
      w_state_nxt   = S_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_row_cnt <= '0;
      r_work    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_work    <= w_work_nxt;
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_work;

endmodule

// File: tb/tb_inv_shift_rows.sv
// Self-checking bench for inv_shift_rows (default build): directed vectors plus random traffic
// compared against a row/column matrix model of InvShiftRows.
module tb_inv_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0]  in_data2, out_data2;

  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;
  bit mon_en = 0;
  logic [127:0] exp_q[$];

  inv_shift_rows #(.DIMENSION(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  inv_shift_rows #(.DIMENSION(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // State as a d x d matrix of bytes: out[r][c] = in[r][(c - r) mod d].
  function automatic logic [127:0] ref_inv(input logic [127:0] x, input int d);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    int           k;
    res = '0;
    for (int c = 0; c < d; c++)
      for (int r = 0; r < d; r++) begin
        k = c * d + r;
        m[r][c] = 8'(x >> (8 * (d * d - 1 - k)));
      end
    for (int c = 0; c < d; c++)
      for (int r = 0; r < d; r++) begin
        k = c * d + r;
        res = res | (128'(m[r][(c - r + d) % d]) << (8 * (d * d - 1 - k)));
      end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(ref_inv(in_data, 4));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_unexpected_out", 1'b1, 1'b0);
        else chk("rand_out", out_data, exp_q.pop_front());
        n_words++;
      end
    end
  end

  logic [127:0] held, w2;
  bit fire;
  int cyc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; out_ready = 1'b1;
    in_valid2 = 1'b1; in_data2 = $urandom; out_ready2 = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid_d2", out_valid2, 1'b0);
    in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle_valid", out_valid, 1'b0);
    chk("post_rst_idle_ready", in_ready, 1'b1);

    // AES vector, then backpressure, then same-edge pass-through
    in_valid = 1'b1;
    in_data = 128'h000102030405060708090a0b0c0d0e0f;
    chk("ref_model_aes", ref_inv(in_data, 4), 128'h000d0a0704010e0b0805020f0c090603);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("aes_in_ready_busy", in_ready, 1'b0);
      chk("aes_out_valid_lat", out_valid, 1'b0);
      tick();
    end
    chk("aes_out_valid", out_valid, 1'b1);
    chk("aes_out_data", out_data, 128'h000d0a0704010e0b0805020f0c090603);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    w2 = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_data = w2; out_ready = 1'b1;
    #1;
    chk("pt_in_ready_comb", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("pt_after_valid", out_valid, 1'b0);
    chk("pt_after_ready", in_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("pt_out_valid", out_valid, (i == 4));
    end
    chk("pt_out_data", out_data, ref_inv(w2, 4));
    tick();
    out_ready = 1'b0;
    chk("pt_back_idle", in_ready, 1'b1);

    // dimension 2
    in_valid2 = 1'b1; in_data2 = 32'h00010203;
    tick();
    in_valid2 = 1'b0;
    tick();
    chk("d2_lat", out_valid2, 1'b0);
    tick();
    chk("d2_out_valid", out_valid2, 1'b1);
    chk("d2_out_data", out_data2, 32'h00030201);
    w2 = {96'h0, $urandom};
    out_ready2 = 1'b1; in_valid2 = 1'b1; in_data2 = w2[31:0];
    tick();
    in_valid2 = 1'b0;
    repeat (2) tick();
    chk("d2_rand_valid", out_valid2, 1'b1);
    chk("d2_rand_data", out_data2, ref_inv(w2, 2));
    tick();
    out_ready2 = 1'b0;

    // reset two cycles after accept
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle", in_ready, 1'b1);
    chk("mid_rst_no_valid", out_valid, 1'b0);
    w2 = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_data = w2;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("after_rst_valid", out_valid, 1'b1);
    chk("after_rst_data", out_data, ref_inv(w2, 4));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // random traffic against the queue model
    mon_en = 1;
    cyc = 0;
    while (n_words < 40 && cyc < 4000) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (fire || !in_valid) begin
        in_valid = ($urandom % 4) != 0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = ($urandom % 3) != 0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    mon_en = 0;
    chk("rand_words", (n_words >= 40), 1'b1);
    chk("rand_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows.md
# inv_shift_rows

AES InvShiftRows stage for the decryption datapath: the inverse of the encrypt-side ShiftRows, cyclically rotating state row r right by r byte positions. The block takes a full state word over a valid/ready handshake, transforms it one row per clock in a working register, and presents the result over a second valid/ready handshake. It sits between the inverse SubBytes and AddRoundKey stages of the decrypt round.

## Interface
- dimension, 4: state is dimension x dimension bytes; legal 2..4; W = 8*dimension*dimension.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_data holds a state word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  W  input state, column-major: byte k = bits [W-1-8k -: 8], row = k mod dimension, col = k / dimension.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  W  result state, same byte order.
- fwd  in  1  present only with INV_SHIFT_ROWS_FWD_EN; 1 selects the forward ShiftRows direction.

## Operation
- Transform: out[r][c] = in[r][(c - r) mod dimension]. Row 0 passes unchanged.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - in_valid && in_ready: capture in_data into the working register, clear row counter, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0.
    - Each cycle rotate row `row_cnt` of the working register in place, then increment `row_cnt`.
    - After row dimension-1 is rotated, go to DONE.
    - Rows are independent, so processing order does not affect the result.
  - DONE: out_valid=1; out_data is stable while out_ready=0.
    - out_ready=1 && in_valid=0: go to IDLE.
    - out_ready=1 && in_valid=1: pass-through. The result is consumed and the new word is captured on the same edge; go to SHIFT, with no bubble cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is combinational from out_ready.
- out_data is the working register:
  - Its value while not out_valid is partially transformed and is not checked.
  - The mode selection (fwd) is captured together with in_data, and is held for that word.
- Reset:
  - Reset values: state=IDLE, row_cnt=0, out_valid=0, out_data=0, in_ready=1.
  - Asserting rst_n mid-SHIFT or in DONE discards the word. No partial result is ever flagged valid.
- in_valid while in_ready=0 is ignored. The producer holds the word until it is accepted.

## Timing
- Accept edge is T. Rows are rotated on edges T+1..T+dimension. out_valid rises after edge T+dimension.
  - Latency is dimension cycles; 4 for AES.
- Throughput with out_ready held at 1: one word per dimension+1 cycles. The DONE pass-through removes the IDLE cycle.
- rst_n takes effect immediately, with no clock required. Deassertion is synchronous to clk by the surrounding reset logic.
- No combinational path from in_data to out_data.

## Configuration
- INV_SHIFT_ROWS_FWD_EN defined:
  - Adds the fwd port.
  - A word captured with fwd=1 is transformed as out[r][c] = in[r][(c + r) mod dimension], the encrypt direction, with identical timing.
  - One instance then serves both the encrypt and decrypt datapaths.
- Not defined: the fwd port is absent, and the inverse transform is the only behaviour.

## Test plan
- Reset: assert rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, in_ready=1. No word is accepted until after deassertion.
- AES vector, dimension=4:
  - in_data=0x000102030405060708090a0b0c0d0e0f accepted at T.
  - Result: out_valid at T+4 with out_data=0x000d0a0704010e0b0805020f0c090603.
  - Check that in_ready=0 on T+1..T+4.
- Backpressure and pass-through:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_data unchanged throughout, in_ready=0.
  - Raise out_ready together with in_valid carrying a second word -> both handshakes complete on the same edge; second result valid 4 cycles later.
- Reset mid-operation: drop rst_n two cycles after accept -> out_valid=0 immediately. After release, state is IDLE and the next word yields a correct result.
- dimension=2: in_data=0x00010203 -> out_data=0x00030201 after 2 cycles.
- With INV_SHIFT_ROWS_FWD_EN, fwd=1: in_data=0x000102030405060708090a0b0c0d0e0f -> out_data=0x00050a0f04090e03080d02070c01060b. Feeding that value back with fwd=0 returns the original word.
